alu_md: RTL and testbench

Parametrised multi-function ALU for the pipelined MIPS core, replacing the purely combinational ALU in EX.
- Single-cycle logic, arithmetic, compare and shift ops, all with a registered result.
- Iterative multiply/divide unit writing HI/LO.
- Valid/ready handshake so the hazard unit can stall EX while a multiply/divide is in flight.

---
 rtl/alu_md_pkg.sv | 37 +++
 rtl/alu_md_md_iter.sv | 159 +++++++++++++++
 rtl/alu_md.sv | 128 ++++++++++++
 tb/tb_alu_md.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the EX-stage multi-function ALU.
//   - 4-bit opcode constants (OP_AND .. OP_DIV)
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - is_muldiv(op): true for opcodes handled by the iterative unit
// Optional feature macro: ALU_MD_SIGNED_EN (signed MULT/DIV).
package alu_md_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    logic r;
    r = (op == OP_MULTU) || (op == OP_DIVU);
`ifdef ALU_MD_SIGNED_EN
    r = r || (op == OP_MULT) || (op == OP_DIV);
`endif
    return r;
  endfunction

endpackage

// File: rtl/alu_md_md_iter.sv
// md_iter: iterative radix-2 multiply / restoring divide, one step per cycle,
// WIDTH steps per operation. Writes HI/LO on the final step.
// Ports:
//   clk, reset     clock, synchronous active-high reset (clears HI/LO, aborts)
//   start          load operands and begin (op selects mul/div)
//   op             opcode of the started operation
//   a, b           operands (multiplicand/dividend, multiplier/divisor)
//   done           high during the final step cycle
//   res_lo         value LO takes at the end of the final step
//   hi, lo         HI/LO registers
// Optional feature macro: ALU_MD_SIGNED_EN (magnitude iteration + sign fix-up).
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     sum, rem_try, diff;
  logic [WIDTH-1:0]   step_acc, step_q, res_hi;
  logic [2*WIDTH-1:0] prod_neg;
  logic               start_div, start_nlo, start_nhi;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // One iteration step. Multiply: {acc,q} holds partial product/multiplier.
  // Divide: acc is the partial remainder, q shifts dividend out / quotient in.
  // A zero divisor needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    rem_try = {acc_q, q_q[WIDTH-1]};
    diff    = rem_try - {1'b0, m_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        step_acc = diff[WIDTH-1:0];
        step_q   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = rem_try[WIDTH-1:0];
        step_q   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = sum[WIDTH:1];
      step_q   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Final result with sign fix-up.
  always_comb begin
    res_hi   = step_acc;
    res_lo   = step_q;
    prod_neg = -{step_acc, step_q};
    if (div_q) begin
      if (neg_lo_q) res_lo = -step_q;
      if (neg_hi_q) res_hi = -step_acc;
    end else if (neg_lo_q) begin
      {res_hi, res_lo} = prod_neg;
    end
  end

  // Operand conditioning at start.
  always_comb begin
    start_div = (op == OP_DIVU);
    start_nlo = 1'b0;
    start_nhi = 1'b0;
    a_mag     = a;
    b_mag     = b;
`ifdef ALU_MD_SIGNED_EN
    if (op == OP_DIV) start_div = 1'b1;
    // Signed divide by zero stays unsigned so it matches DIVU by zero.
    if ((op == OP_MULT) || ((op == OP_DIV) && (b != '0))) begin
      a_mag     = a[WIDTH-1] ? -a : a;
      b_mag     = b[WIDTH-1] ? -b : b;
      start_nlo = a[WIDTH-1] ^ b[WIDTH-1];
      start_nhi = (op == OP_DIV) && a[WIDTH-1];
    end
`endif
  end

  assign done = (cnt_q == CW'(1));

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (start) begin
      cnt_d    = CW'(WIDTH);
      div_d    = start_div;
      neg_lo_d = start_nlo;
      neg_hi_d = start_nhi;
      acc_d    = '0;
      q_d      = a_mag;
      m_d      = b_mag;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = step_acc;
      q_d   = step_q;
      if (done) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with registered single-cycle ops and an iterative
// multiply/divide unit writing HI/LO, behind a valid/ready handshake.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/ready   request handshake (transfer when both high)
//   control          4-bit opcode
//   in1, in2         operands A and B (shift amount in in2[SHW-1:0])
//   out, zero        registered result and (out == 0)
//   out_valid        one-cycle pulse marking a new out/zero
//   hi, lo           HI/LO registers
// Optional feature macro: ALU_MD_SIGNED_EN (signed MULT/DIV opcodes).
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, md_start, md_done;
  logic [WIDTH-1:0] md_res_lo;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   sh;

  assign in_ready = (state_q != BUSY);
  assign accept   = in_valid && in_ready;
  assign sh       = in2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (control)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_ADD:  alu_res = in1 + in2;
      OP_XOR:  alu_res = in1 ^ in2;
      OP_SUB:  alu_res = in1 - in2;
      OP_NOR:  alu_res = ~(in1 | in2);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLL:  alu_res = in1 << sh;
      OP_SRL:  alu_res = in1 >> sh;
      OP_SRA:  alu_res = $signed(in1) >>> sh;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    md_start    = 1'b0;
    case (state_q)
      BUSY: begin
        if (md_done) begin
          state_d     = DONE;
          out_d       = md_res_lo;
          zero_d      = (md_res_lo == '0);
          out_valid_d = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE when nothing comes.
        state_d = IDLE;
        if (accept) begin
          if (is_muldiv(control)) begin
            state_d  = BUSY;
            md_start = 1'b1;
          end else begin
            out_d       = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_q       <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (control),
    .a      (in1),
    .b      (in2),
    .done   (md_done),
    .res_lo (md_res_lo),
    .hi     (hi),
    .lo     (lo)
  );

  assign out       = out_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   control;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out, hi, lo;
  logic         zero, out_valid;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .zero      (zero),
    .out_valid (out_valid),
    .hi        (hi),
    .lo        (lo)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one operation must produce, from plain arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output bit md, output logic [W-1:0] r,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint unsigned up;
    int sa, sb;
`ifdef ALU_MD_SIGNED_EN
    longint sp;
`endif
    md = 0; r = '0; rh = '0; rl = '0;
    sa = a; sb = b;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1000: r = (a < b) ? 1 : 0;
      4'b0100: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: r = W'(sa >>> b[4:0]);
      4'b1001: begin md = 1; up = 64'(a) * 64'(b); {rh, rl} = up; end
      4'b1010: begin
        md = 1;
        if (b == 0) begin rl = '1; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
`ifdef ALU_MD_SIGNED_EN
      4'b1011: begin md = 1; sp = longint'(sa) * longint'(sb); {rh, rl} = sp; end
      4'b1110: begin
        md = 1;
        if (b == 0) begin rl = '1; rh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = 0; end
        else begin rl = sa / sb; rh = sa % sb; end
      end
`endif
      default: r = '0;
    endcase
  endfunction

  // Model state: values the outputs must show during the next cycle.
  logic [W-1:0] m_out, m_hi, m_lo, p_hi, p_lo;
  logic         m_zero, m_valid, m_ready;
  int           m_busy;

  always @(posedge clk) begin
    bit md;
    logic [W-1:0] r, rh, rl;
    m_valid = 0;
    if (reset) begin
      m_out = '0; m_zero = 1; m_hi = '0; m_lo = '0; m_ready = 1; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1; m_out = p_lo; m_zero = (p_lo == 0);
        m_hi = p_hi; m_lo = p_lo; m_ready = 1;
      end
    end else if (in_valid) begin
      ref_op(control, in1, in2, md, r, rh, rl);
      if (md) begin
        m_busy = W; m_ready = 0; p_hi = rh; p_lo = rl;
      end else begin
        m_valid = 1; m_out = r; m_zero = (r == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_ready);
      chk("out_valid", out_valid, m_valid);
      chk("out", out, m_out);
      chk("zero", zero, m_zero);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    control = op; in1 = a; in2 = b; in_valid = 1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", (n < 200) ? 1 : 0, 1);
    @(negedge clk);
    in_valid = 0; control = 4'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("valid_timeout", out_valid, 1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 20);
      1: begin
        logic [W-1:0] c [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        return c[$urandom_range(0, 3)];
      end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1; in_valid = 0; control = 0; in1 = 0; in2 = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_hi", hi, 0);
    reset = 0;
    @(negedge clk);

    // 1. ADD / SUB
    issue(4'b0010, 5, 7);
    chk("add_valid", out_valid, 1); chk("add_out", out, 12); chk("add_zero", zero, 0);
    issue(4'b0110, 5, 5);
    chk("sub_out", out, 0); chk("sub_zero", zero, 1);

    // 2. compares and arithmetic shift
    issue(4'b0111, 32'hFFFF_FFFF, 1); chk("slt_out", out, 1);
    issue(4'b1000, 32'hFFFF_FFFF, 1); chk("sltu_out", out, 0);
    issue(4'b1101, 32'h8000_0000, 4); chk("sra_out", out, 32'hF800_0000);

    // 3. MULTU latency and back-to-back issue
    issue(4'b1001, 32'hFFFF_FFFF, 2);
    for (int i = 1; i <= W; i++) begin
      chk("mul_busy_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("mul_valid", out_valid, 1);
    chk("mul_hi", hi, 1);
    chk("mul_lo", lo, 32'hFFFF_FFFE);
    chk("mul_out", out, 32'hFFFF_FFFE);
    issue(4'b0010, 1, 2);
    chk("b2b_add_out", out, 3);
    chk("b2b_add_valid", out_valid, 1);

    // 4. DIVU
    issue(4'b1010, 100, 7);
    wait_valid(n);
    chk("divu_latency", n, W);
    chk("divu_lo", lo, 14); chk("divu_hi", hi, 2);
    issue(4'b1010, 9, 0);
    wait_valid(n);
    chk("div0_lo", lo, 32'hFFFF_FFFF); chk("div0_hi", hi, 9);

    // 5. reset mid-MULTU
    issue(4'b1001, 1234, 5678);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
    chk("abort_ready", in_ready, 1); chk("abort_valid", out_valid, 0);
    repeat (40) @(negedge clk);

    // 6. signed feature
`ifdef ALU_MD_SIGNED_EN
    issue(4'b1011, -3, 4);
    wait_valid(n);
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFF4);
    issue(4'b1110, -7, 2);
    wait_valid(n);
    chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(n);
    chk("divovf_lo", lo, 32'h8000_0000); chk("divovf_hi", hi, 0);
`else
    issue(4'b1010, 9, 0);
    wait_valid(n);
    issue(4'b1011, 3, 4);
    chk("ill_valid", out_valid, 1); chk("ill_out", out, 0); chk("ill_zero", zero, 1);
    chk("ill_hi", hi, 9); chk("ill_lo", lo, 32'hFFFF_FFFF);
    issue(4'b1110, 7, 2);
    chk("ill2_ready", in_ready, 1); chk("ill2_hi", hi, 9);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 300; k++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
